// File: rtl/tetris_pkg.sv
// tetris_pkg: shared board geometry and collision-checker FSM states.
package tetris_pkg;
   localparam int BOARD_W    = 10;
   localparam int BOARD_H    = 24;
   localparam int BOARD_BITS = 240;
   typedef enum logic [1:0] {IDLE, SCAN, DONE} chk_state_t;
endpackage

// File: rtl/piece_row_probe.sv
// piece_row_probe: checks one 4-cell piece row against walls, floor and a board snapshot.
module piece_row_probe
   import tetris_pkg::*;
#(
   parameter int BOARD_W = tetris_pkg::BOARD_W,
   parameter int BOARD_H = tetris_pkg::BOARD_H
) (
   input  logic [3:0]                 mask_row,
   input  logic signed [4:0]          col,
   input  logic [5:0]                 row,
   input  logic [BOARD_W*BOARD_H-1:0] snap,
   output logic                       hit_wall,
   output logic                       hit_floor,
   output logic                       hit_block
);
   localparam int IW = $clog2(BOARD_W*BOARD_H);
   localparam logic signed [5:0] MAX_COL = 6'(BOARD_W-1);
   localparam logic [5:0] MAX_ROW = 6'(BOARD_H-1);
   logic [3:0] w, f, b;
   for (genvar c = 0; c < 4; c++) begin : g_col
      logic signed [5:0] cc;
      logic [IW-1:0] idx;
      assign cc = {col[4], col} + 6'(c);
      assign w[c] = mask_row[c] && (cc[5] || cc > MAX_COL);
      assign f[c] = mask_row[c] && (row > MAX_ROW);
      // index is forced to 0 whenever the cell is off the board
      assign idx = (w[c] || f[c]) ? '0 : IW'(int'(row) * BOARD_W + int'(cc));
      assign b[c] = mask_row[c] && !w[c] && !f[c] && snap[idx];
   end
   assign hit_wall  = |w;
   assign hit_floor = |f;
   assign hit_block = |b;
endmodule

// File: rtl/piece_collision_checker.sv
// piece_collision_checker: scans a 4x4 piece against a captured board snapshot, one piece row per cycle.
// Define COLLIDE_EARLY_EXIT_EN to stop scanning once any row has raised a flag.
module piece_collision_checker
   import tetris_pkg::*;
#(
   parameter int BOARD_W = tetris_pkg::BOARD_W,
   parameter int BOARD_H = tetris_pkg::BOARD_H
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [BOARD_W*BOARD_H-1:0] board,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic signed [4:0]          cand_col,
   input  logic [4:0]                 cand_row,
   input  logic [15:0]                piece_mask,
   output logic                       resp_valid,
   input  logic                       resp_ready,
   output logic                       collide,
   output logic                       hit_wall,
   output logic                       hit_floor,
   output logic                       hit_block
);
   chk_state_t state, state_nx;
   logic [1:0] cnt;
   logic [15:0] mask;
   logic signed [4:0] col;
   logic [4:0] row;
   logic [BOARD_W*BOARD_H-1:0] snap;
   logic pw, pf, pb, stop;

   piece_row_probe #(.BOARD_W(BOARD_W), .BOARD_H(BOARD_H)) u_probe (
      .mask_row (mask[{cnt, 2'b00} +: 4]),
      .col      (col),
      .row      ({1'b0, row} + {4'b0, cnt}),
      .snap     (snap),
      .hit_wall (pw),
      .hit_floor(pf),
      .hit_block(pb)
   );

`ifdef COLLIDE_EARLY_EXIT_EN
   assign stop = hit_wall | hit_floor | hit_block;
`else
   assign stop = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = req_valid ? SCAN : IDLE;
         SCAN:    state_nx = (stop || cnt == 2'd3) ? DONE : SCAN;
         DONE:    state_nx = resp_ready ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         mask      <= '0;
         col       <= '0;
         row       <= '0;
         snap      <= '0;
         hit_wall  <= 1'b0;
         hit_floor <= 1'b0;
         hit_block <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && req_valid) begin
            cnt       <= '0;
            mask      <= piece_mask;
            col       <= cand_col;
            row       <= cand_row;
            snap      <= board;
            hit_wall  <= 1'b0;
            hit_floor <= 1'b0;
            hit_block <= 1'b0;
         end else if (state == SCAN && !stop) begin
            cnt       <= cnt + 2'd1;
            hit_wall  <= hit_wall | pw;
            hit_floor <= hit_floor | pf;
            hit_block <= hit_block | pb;
         end
      end
   end

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == DONE);
   assign collide    = hit_wall | hit_floor | hit_block;
endmodule

// File: tb/tb_piece_collision_checker.sv
// tb_piece_collision_checker: directed and random piece checks against a cell-by-cell reference model.
module tb_piece_collision_checker;
   localparam int BW = 10, BH = 24, NB = BW * BH;
`ifdef COLLIDE_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif
   logic clk = 1'b0, reset;
   logic [NB-1:0] board;
   logic req_valid, req_ready, resp_valid, resp_ready;
   logic signed [4:0] cand_col;
   logic [4:0] cand_row;
   logic [15:0] piece_mask;
   logic collide, hit_wall, hit_floor, hit_block;
   int n_checks = 0, n_fail = 0;

   always #5 clk = ~clk;

   piece_collision_checker dut (
      .clk(clk), .reset(reset), .board(board),
      .req_valid(req_valid), .req_ready(req_ready),
      .cand_col(cand_col), .cand_row(cand_row), .piece_mask(piece_mask),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .collide(collide), .hit_wall(hit_wall), .hit_floor(hit_floor), .hit_block(hit_block)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // flags as {wall, floor, block}; lat = edges from accept to resp_valid
   function automatic logic [2:0] model(input logic [NB-1:0] b, input int col, input int row,
                                        input logic [15:0] m, output int lat);
      logic [2:0] fl;
      fl = '0;
      lat = 4;
      for (int r = 0; r < 4; r++) begin
         logic [2:0] rf;
         rf = '0;
         for (int c = 0; c < 4; c++) begin
            if (m[4*r+c]) begin
               int x, y;
               x = col + c;
               y = row + r;
               if (x < 0 || x >= BW) rf[2] = 1'b1;
               if (y >= BH) rf[1] = 1'b1;
               if (x >= 0 && x < BW && y < BH && b[y*BW+x]) rf[0] = 1'b1;
            end
         end
         fl |= rf;
         if (EARLY && rf != 0) begin
            lat = (r + 2 < 4) ? r + 2 : 4;
            break;
         end
      end
      return fl;
   endfunction

   task automatic run(input string tag, input int col, input int row, input logic [15:0] m, input int hold);
      logic [2:0] ef;
      int elat, lat;
      ef = model(board, col, row, m, elat);
      check({tag, "/req_ready_idle"}, req_ready, 1);
      cand_col = 5'(col);
      cand_row = 5'(row);
      piece_mask = m;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      cand_col = 5'($urandom);
      cand_row = 5'($urandom);
      piece_mask = 16'($urandom);
      for (int i = 0; i < NB; i++) board[i] = 1'($urandom_range(0, 1));
      check({tag, "/req_ready_busy"}, req_ready, 0);
      lat = 0;
      while (!resp_valid && lat < 12) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "/latency"}, lat, elat);
      check({tag, "/flags"}, {hit_wall, hit_floor, hit_block}, ef);
      check({tag, "/collide"}, collide, |ef);
      req_valid = (hold > 0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, "/hold_valid"}, resp_valid, 1);
         check({tag, "/hold_flags"}, {collide, hit_wall, hit_floor, hit_block}, {|ef, ef});
         check({tag, "/hold_ready"}, req_ready, 0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      req_valid = 1'b0;
      check({tag, "/post_valid"}, resp_valid, 0);
      check({tag, "/post_ready"}, req_ready, 1);
   endtask

   initial begin
      reset = 1'b1;
      req_valid = 1'b0;
      resp_ready = 1'b0;
      board = '0;
      cand_col = '0;
      cand_row = '0;
      piece_mask = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", req_ready, 1);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_flags", {collide, hit_wall, hit_floor, hit_block}, 0);
      reset = 1'b0;

      board = '0; run("o_empty", 4, 0, 16'h0033, 0);
      board = '0; run("i_h_col7", 7, 0, 16'h000F, 3);
      board = '0; run("i_h_colm1", -1, 0, 16'h000F, 0);
      board = '0; run("i_v_row21", 0, 21, 16'h1111, 0);
      board = '0; run("i_v_row20", 0, 20, 16'h1111, 0);
      board = '0; board[5*BW+3] = 1'b1; run("o_block", 2, 4, 16'h0033, 2);
      board = '1; run("mask0", -3, 30, 16'h0000, 0);
      board = '0; run("i_h_col8", 8, 0, 16'h000F, 0);

      board = '0;
      cand_col = 5'sd4;
      cand_row = 5'd0;
      piece_mask = 16'h0033;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midscan_req_ready", req_ready, 1);
      check("midscan_resp_valid", resp_valid, 0);
      check("midscan_flags", {collide, hit_wall, hit_floor, hit_block}, 0);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("midscan_no_resp", resp_valid, 0);
      end

      for (int k = 0; k < 40; k++) begin
         int c, r;
         for (int i = 0; i < NB; i++) board[i] = ($urandom_range(0, 3) == 0);
         c = (k % 2 == 0) ? int'($urandom_range(0, 31)) - 16 : int'($urandom_range(0, 11)) - 2;
         r = (k % 2 == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 22));
         run("random", c, r, 16'($urandom), int'($urandom_range(0, 2)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
